// File: rtl/fifo_rd_streamer_if.sv
// Stream-side bundle for fifo_rd_streamer: FIFO read port, valid/ready output, status.
// master is the streamer itself; slave is whatever sits around it (FIFO + consumer).
interface fifo_rd_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  enable;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [CNT_WIDTH-1:0]  words_out;
    logic                  busy;

    modport master (
        input  enable, fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, words_out, busy
    );

    modport slave (
        output enable, fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, words_out, busy
    );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream through a 3-entry buffer.
// Reads are only issued when the buffer can absorb every word already requested.
module fifo_rd_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               rd_clk,
    input  logic               rst,
    fifo_rd_streamer_if.master bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic [1:0]            head_reg;
    logic [1:0]            tail_reg;
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic                  inflight_reg;
    logic [CNT_WIDTH-1:0]  words_reg;
    logic [2:0]            pending;
    logic                  rd_en;
    logic                  capture;
    logic                  pop;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Counting the in-flight word guarantees it always lands in a free slot.
    assign pending = {1'b0, occ_reg} + {2'b00, inflight_reg};
    assign rd_en   = !rst && bus.enable && !bus.fifo_empty && (pending < 3'd3);
    assign capture = inflight_reg;
    assign pop     = (occ_reg != 2'd0) && bus.m_ready;

    always_comb begin
        occ_next = occ_reg;
        if (capture && !pop) begin
            occ_next = occ_reg + 2'd1;
        end else if (!capture && pop) begin
            occ_next = occ_reg - 2'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            head_reg     <= 2'd0;
            tail_reg     <= 2'd0;
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            words_reg    <= '0;
        end else begin
            inflight_reg <= rd_en;
            occ_reg      <= occ_next;
            if (capture) begin
                tail_reg <= wrap_inc(tail_reg);
            end
            if (pop) begin
                head_reg  <= wrap_inc(head_reg);
                words_reg <= words_reg + CNT_ONE;
            end
        end
    end

    // Storage carries no reset; occupancy alone says which entries are live.
    always_ff @(posedge rd_clk) begin
        if (capture) begin
            buf_mem[tail_reg] <= bus.fifo_rd_data;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ_reg != 2'd0);
    assign bus.m_data     = buf_mem[head_reg];
    assign bus.words_out  = words_reg;
    assign bus.busy       = (occ_reg != 2'd0) || inflight_reg;
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: a queue-level model of buffered and in-flight words
// is checked against the DUT every cycle, plus literal expectations per scenario.
module tb_fifo_rd_streamer;
    logic clk;
    logic rst;

    fifo_rd_streamer_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();

    fifo_rd_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .rd_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Environment: words still sitting in the FIFO.
    logic [7:0] src[$];
    // Model: words the streamer holds, plus the one requested last cycle.
    logic [7:0] mbuf[$];
    logic       inflight = 1'b0;
    logic [7:0] inflight_word = 8'h00;
    logic [15:0] cnt = 16'h0;
    logic       tog_mode = 1'b0;
    logic       tog = 1'b0;

    // Per-scenario logs of observed activity.
    int         rd_cyc[$];
    int         hs_cyc[$];
    logic [7:0] hs_data[$];
    logic [7:0] read_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        hs_cyc.delete();
        hs_data.delete();
        read_log.delete();
    endtask

    task automatic tick();
        logic exp_rd;
        logic exp_valid;
        bus.fifo_empty = (src.size() == 0) || (tog_mode && tog);
        @(negedge clk);
        exp_rd    = !rst && bus.enable && !bus.fifo_empty && ((mbuf.size() + int'(inflight)) < 3);
        exp_valid = (mbuf.size() != 0);
        check("fifo_rd_en", bus.fifo_rd_en, exp_rd);
        check("rd_en_while_empty", bus.fifo_rd_en && bus.fifo_empty, 0);
        check("m_valid", bus.m_valid, exp_valid);
        if (exp_valid) check("m_data", bus.m_data, mbuf[0]);
        check("busy", bus.busy, exp_valid || inflight);
        check("words_out", bus.words_out, cnt);
        if (bus.fifo_rd_en) rd_cyc.push_back(cyc);
        if (bus.m_valid && bus.m_ready) begin
            hs_data.push_back(bus.m_data);
            hs_cyc.push_back(cyc);
            $display("cycle %0d: word %02h delivered", cyc, bus.m_data);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mbuf.delete();
            inflight = 1'b0;
            cnt = 16'h0;
        end else begin
            if (exp_valid && bus.m_ready) begin
                void'(mbuf.pop_front());
                cnt = cnt + 16'h1;
            end
            if (inflight) mbuf.push_back(inflight_word);
            inflight = exp_rd;
            if (exp_rd) begin
                inflight_word = src.pop_front();
                read_log.push_back(inflight_word);
            end
        end
        bus.fifo_rd_data = exp_rd ? inflight_word : 8'($urandom);
        cyc++;
        tog = !tog;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp3 [5];
        int n;
        int errs;

        rst = 1'b1;
        bus.enable = 1'b1;
        bus.m_ready = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.fifo_rd_data = 8'h00;
        @(posedge clk);
        #1;

        // 1: reset held with data available
        clear_logs();
        src.push_back(8'h77);
        repeat (3) tick();
        check("t1 rd_en count", rd_cyc.size(), 0);
        check("t1 handshakes", hs_data.size(), 0);
        check("t1 words_out", bus.words_out, 0);
        src.delete();
        rst = 1'b0;

        // 2: basic three-word stream
        reset_pulse();
        clear_logs();
        src = '{8'hAA, 8'hBB, 8'hCC};
        bus.enable = 1'b1;
        bus.m_ready = 1'b1;
        repeat (8) tick();
        check("t2 rd_en count", rd_cyc.size(), 3);
        check("t2 handshakes", hs_data.size(), 3);
        if (rd_cyc.size() == 3 && hs_data.size() == 3) begin
            check("t2 rd_en consecutive", rd_cyc[2] - rd_cyc[0], 2);
            check("t2 latency", hs_cyc[0] - rd_cyc[0], 2);
            check("t2 out consecutive", hs_cyc[2] - hs_cyc[0], 2);
            check("t2 word0", hs_data[0], 8'hAA);
            check("t2 word1", hs_data[1], 8'hBB);
            check("t2 word2", hs_data[2], 8'hCC);
        end
        check("t2 words_out", bus.words_out, 3);
        check("t2 busy", bus.busy, 0);

        // 3: backpressure then release
        reset_pulse();
        clear_logs();
        exp3 = '{8'hDD, 8'hEE, 8'h11, 8'h22, 8'h33};
        src = '{8'hDD, 8'hEE, 8'h11, 8'h22, 8'h33};
        bus.m_ready = 1'b0;
        repeat (6) tick();
        check("t3 reads while stalled", rd_cyc.size(), 3);
        check("t3 m_valid held", bus.m_valid, 1);
        check("t3 m_data held", bus.m_data, 8'hDD);
        bus.m_ready = 1'b1;
        n = 0;
        while (hs_data.size() < 5 && n < 20) begin
            tick();
            n++;
        end
        check("t3 handshakes", hs_data.size(), 5);
        if (hs_data.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t3 order", hs_data[i], exp3[i]);
            check("t3 no gaps", hs_cyc[4] - hs_cyc[0], 4);
        end
        check("t3 words_out", bus.words_out, 5);

        // 4: enable dropped right after one strobe
        reset_pulse();
        clear_logs();
        src = '{8'h44, 8'h55, 8'h66, 8'h77};
        bus.enable = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        bus.enable = 1'b0;
        repeat (8) tick();
        check("t4 rd_en count", rd_cyc.size(), 1);
        check("t4 handshakes", hs_data.size(), 1);
        if (hs_data.size() == 1) check("t4 word", hs_data[0], 8'h44);
        check("t4 m_valid drained", bus.m_valid, 0);
        check("t4 busy", bus.busy, 0);
        src.delete();

        // 5: fifo_empty toggling, random backpressure, 200 words
        bus.enable = 1'b1;
        reset_pulse();
        clear_logs();
        tog_mode = 1'b1;
        for (int i = 0; i < 200; i++) src.push_back(8'($urandom));
        n = 0;
        while (hs_data.size() < 200 && n < 3000) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("t5 handshakes", hs_data.size(), 200);
        check("t5 reads", read_log.size(), 200);
        errs = 0;
        if (hs_data.size() == 200 && read_log.size() == 200) begin
            for (int i = 0; i < 200; i++) if (hs_data[i] !== read_log[i]) errs++;
        end
        check("t5 order errors", errs, 0);
        check("t5 words_out", bus.words_out, 200);
        tog_mode = 1'b0;

        // 6: reset with occ=2, inflight=1, then a fresh word
        reset_pulse();
        clear_logs();
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        bus.enable = 1'b1;
        bus.m_ready = 1'b0;
        repeat (3) tick();
        check("t6 reads before rst", rd_cyc.size(), 3);
        check("t6 m_valid before rst", bus.m_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 m_valid after rst", bus.m_valid, 0);
        check("t6 words_out after rst", bus.words_out, 0);
        check("t6 busy after rst", bus.busy, 0);
        src.delete();
        src.push_back(8'h5A);
        bus.m_ready = 1'b1;
        clear_logs();
        n = 0;
        while (hs_data.size() < 1 && n < 10) begin
            tick();
            n++;
        end
        check("t6 handshakes", hs_data.size(), 1);
        if (hs_data.size() == 1) check("t6 word", hs_data[0], 8'h5A);
        tick();
        check("t6 words_out", bus.words_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
